conv_result_drain: RTL and testbench
====================================

CONV_RESULT_DRAIN -- requirements
Module: conv_result_drain

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 12, giving the result element width.
REQ-002 The block SHALL have parameter RESULT_W, default 14, giving the result width in elements.
REQ-003 The block SHALL have parameter RESULT_H, default 14, giving the result height in elements.
REQ-004 The block SHALL have parameter RESULT_RAM_ADDR_WIDTH, default $clog2(RESULT_W*RESULT_H), giving the result RAM address width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-007 The block SHALL have port start, input, 1 bit: one-cycle pulse, the last-value strobe from the conv datapath.
REQ-008 The block SHALL have port result_rden, output, 1 bit: result RAM read enable.
REQ-009 The block SHALL have port result_rdaddress, output, RESULT_RAM_ADDR_WIDTH bits: result RAM read address, w + h*RESULT_W.
REQ-010 The block SHALL have port result_data_in, input, DATA_WIDTH bits: result RAM read data, valid exactly 1 cycle after result_rden.
REQ-011 The block SHALL have port out_data, output, DATA_WIDTH bits: streamed result element.
REQ-012 The block SHALL have port out_addr, output, RESULT_RAM_ADDR_WIDTH bits: RAM address of out_data.
REQ-013 The block SHALL have port out_last, output, 1 bit: high with the element at address N-1, where N = RESULT_W*RESULT_H.
REQ-014 The block SHALL have ports out_val (output, 1 bit) and out_rdy (input, 1 bit): valid/ready handshake.
REQ-015 The block SHALL have port busy, output, 1 bit: high in DRAIN.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse when the drain completes.

Function
REQ-017 The block SHALL implement an FSM with two states: IDLE and DRAIN.
REQ-018 The FSM SHALL go IDLE->DRAIN on start=1; on that transition the read counter, in-flight flag and output FIFO SHALL be cleared.
REQ-019 start received in DRAIN SHALL be ignored, with no restart and no counter change.
REQ-020 In DRAIN the block SHALL issue one read per cycle, in order, for addresses 0..N-1, each only when issue is allowed.
REQ-021 Issue SHALL be allowed iff fifo_count + inflight - pop < 2, where pop = out_val & out_rdy. The read SHALL be issued in the same cycle as the pop, so a full-rate stream is sustained.
REQ-022 Read data SHALL be captured into a 2-entry output FIFO together with its address, one cycle after issue.
REQ-023 out_val SHALL equal FIFO non-empty; out_data, out_addr and out_last SHALL come from the FIFO head and hold stable while out_val=1 and out_rdy=0.
REQ-024 Latency: start in cycle 0 -> result_rden=1 with address 0 in cycle 1 -> out_val=1 with element 0 in cycle 2.
REQ-025 Throughput: with out_rdy held at 1, the block SHALL output one element per cycle, with element N-1 in cycle N+1.
REQ-026 When all N reads are issued, nothing is in flight and the final pop occurs, done SHALL pulse in the next cycle, busy SHALL drop and the FSM SHALL return to IDLE.
REQ-027 result_rden SHALL never be asserted in IDLE, and never more than N times per drain.
REQ-028 The address counter SHALL NOT wrap; it SHALL saturate at N once issue is complete.
REQ-029 A start in the same cycle as done SHALL be ignored; start is accepted only from IDLE.

Reset
REQ-030 On reset=0, asynchronously: FSM=IDLE; FIFO empty; counters 0; result_rden, out_val, out_last, busy and done = 0; out_data, out_addr and result_rdaddress = 0.
REQ-031 Reset mid-DRAIN SHALL abort the drain with no done pulse; read data returning after reset is released SHALL be discarded.

Structure
REQ-032 The shared conv package SHALL hold the FSM state typedef (IDLE, DRAIN) and the FIFO depth constant (2).
REQ-033 The output FIFO SHALL be a separate sub-module, conv_drain_fifo2 (2-entry, data+addr+last, with count output).

Verification
REQ-034 The bench SHALL use RESULT_W=2, RESULT_H=2, RAM preloaded with 10,11,12,13, out_rdy=1; start in cycle 0 -> out_data 10,11,12,13 in cycles 2-5, out_last in cycle 5, done in cycle 6.
REQ-035 Same setup with out_rdy=0 in cycles 0-9, then 1 -> at most 2 reads issued before cycle 10, no data lost or reordered, output 10,11,12,13.
REQ-036 out_rdy toggling 1,0,1,0 -> out_data/out_addr held stable during stalls; all 4 elements output exactly once.
REQ-037 A second start pulse in cycle 3 of a drain -> ignored; exactly 4 reads and one done pulse.
REQ-038 reset=0 in cycle 3, released in cycle 5, then start -> all outputs 0 during reset, no done; the new drain outputs 10..13 from address 0.

Source files
------------

// File: rtl/conv_result_drain_pkg.sv
// Shared types and constants for the conv result drain: FSM state encoding
// and output FIFO geometry.
package conv_result_drain_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/conv_drain_fifo2.sv
// Two-entry fall-through FIFO holding result element, its RAM address and
// the last flag; an arriving element is visible at the head while empty.
module conv_drain_fifo2
    import conv_result_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_last,
    input  logic                  rd_en,
    output logic                  out_val,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem;
    logic [FIFO_PTR_W-1:0] rd_ptr_q;
    logic [FIFO_PTR_W-1:0] wr_ptr_q;
    logic [FIFO_CNT_W-1:0] count_q;
    logic                  stored;
    logic                  push;
    logic                  pull;

    // An element popped in its arrival cycle never needs a storage slot.
    assign stored  = (count_q != '0);
    assign push    = wr_en && !(!stored && rd_en);
    assign pull    = rd_en && stored;
    assign out_val = stored || wr_en;
    assign count   = count_q;

    always_comb begin
        out_data = '0;
        out_addr = '0;
        out_last = 1'b0;
        if (stored) begin
            out_data = data_mem[rd_ptr_q];
            out_addr = addr_mem[rd_ptr_q];
            out_last = last_mem[rd_ptr_q];
        end else if (wr_en) begin
            out_data = wr_data;
            out_addr = wr_addr;
            out_last = wr_last;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pull) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + FIFO_CNT_W'(push) - FIFO_CNT_W'(pull);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= wr_data;
            addr_mem[wr_ptr_q] <= wr_addr;
            last_mem[wr_ptr_q] <= wr_last;
        end
    end

endmodule

// File: rtl/conv_result_drain.sv
// Streams the conv result RAM out over a valid/ready port, one element per
// cycle, after the datapath strobes its last value.
module conv_result_drain
    import conv_result_drain_pkg::*;
#(
    parameter int DATA_WIDTH            = 12,
    parameter int RESULT_W              = 14,
    parameter int RESULT_H              = 14,
    parameter int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W * RESULT_H)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             result_rden,
    output logic [RESULT_RAM_ADDR_WIDTH-1:0] result_rdaddress,
    input  logic [DATA_WIDTH-1:0]            result_data_in,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [RESULT_RAM_ADDR_WIDTH-1:0] out_addr,
    output logic                             out_last,
    output logic                             out_val,
    input  logic                             out_rdy,
    output logic                             busy,
    output logic                             done
);

    localparam int N     = RESULT_W * RESULT_H;
    localparam int CNT_W = RESULT_RAM_ADDR_WIDTH + 1;

    drain_state_t                     state_q, state_d;
    logic [CNT_W-1:0]                 rd_cnt_q;
    logic                             vld_p1;
    logic [RESULT_RAM_ADDR_WIDTH-1:0] addr_p1;
    logic                             done_q;
    logic [FIFO_CNT_W-1:0]            fifo_count;
    logic [2:0]                       occupancy;
    logic                             pop;
    logic                             all_issued;
    logic                             issue;
    logic                             accept;
    logic                             drain_end;

    // Counting the pop in the same cycle keeps a read going out every cycle.
    assign pop        = out_val && out_rdy;
    assign all_issued = (rd_cnt_q == CNT_W'(N));
    assign occupancy  = 3'(fifo_count) + 3'(vld_p1);
    assign issue      = (state_q == DRAIN) && !all_issued &&
                        ((occupancy - 3'(pop)) < 3'd2);
    assign accept     = (state_q == IDLE) && start && !done_q;
    assign drain_end  = (state_q == DRAIN) && all_issued && pop &&
                        (occupancy == 3'd1);

    assign result_rden      = issue;
    assign result_rdaddress = issue ? rd_cnt_q[RESULT_RAM_ADDR_WIDTH-1:0] : '0;
    assign busy             = (state_q == DRAIN);
    assign done             = done_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = DRAIN;
            DRAIN:   if (drain_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            vld_p1   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= drain_end;
            if (accept) begin
                rd_cnt_q <= '0;
                vld_p1   <= 1'b0;
            end else begin
                if (issue) rd_cnt_q <= rd_cnt_q + 1'b1;
                vld_p1 <= issue;
            end
        end
    end

    // Stage p1: address of the read whose data returns this cycle.
    always_ff @(posedge clk) begin
        if (issue) addr_p1 <= rd_cnt_q[RESULT_RAM_ADDR_WIDTH-1:0];
    end

    conv_drain_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (RESULT_RAM_ADDR_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clr      (accept),
        .wr_en    (vld_p1),
        .wr_data  (result_data_in),
        .wr_addr  (addr_p1),
        .wr_last  (addr_p1 == RESULT_RAM_ADDR_WIDTH'(N - 1)),
        .rd_en    (pop),
        .out_val  (out_val),
        .out_data (out_data),
        .out_addr (out_addr),
        .out_last (out_last),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_conv_result_drain.sv
// Directed bench for conv_result_drain on a 2x2 result with a one-cycle
// latency RAM model and a scoreboard of expected output elements.
module tb_conv_result_drain;

    localparam int DW = 12;
    localparam int AW = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic          result_rden;
    logic [AW-1:0] result_rdaddress;
    logic [DW-1:0] result_data_in;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          out_val;
    logic          out_rdy;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [4];
    exp_t          exp_q [$];

    int            tests;
    int            fails;
    int            cyc;
    int            rd_count;
    int            done_count;
    int            exp_rd_addr;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;

    conv_result_drain #(
        .DATA_WIDTH (DW),
        .RESULT_W   (2),
        .RESULT_H   (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .result_rden      (result_rden),
        .result_rdaddress (result_rdaddress),
        .result_data_in   (result_data_in),
        .out_data         (out_data),
        .out_addr         (out_addr),
        .out_last         (out_last),
        .out_val          (out_val),
        .out_rdy          (out_rdy),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (result_rden) result_data_in <= mem[result_rdaddress];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, then sample and monitor.
    task automatic tick(input logic st, input logic rdy, input logic rst_n);
        exp_t e;
        @(negedge clk);
        start   = st;
        out_rdy = rdy;
        reset   = rst_n;
        #1;
        cyc++;
        if (!reset) prev_stall = 1'b0;
        if (result_rden) begin
            check("rden_in_busy", 32'(busy), 32'd1);
            check("rd_addr", 32'(result_rdaddress), 32'(exp_rd_addr));
            exp_rd_addr++;
            rd_count++;
        end
        if (done) done_count++;
        if (prev_stall) begin
            check("hold_val", 32'(out_val), 32'd1);
            check("hold_data", 32'(out_data), 32'(prev_data));
            check("hold_addr", 32'(out_addr), 32'(prev_addr));
        end
        if (out_val && out_rdy) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 32'(out_data), 32'(e.data));
                check("sb_addr", 32'(out_addr), 32'(e.addr));
                check("sb_last", 32'(out_last), 32'(e.last));
            end
        end
        prev_stall = out_val && !out_rdy;
        prev_data  = out_data;
        prev_addr  = out_addr;
    endtask

    task automatic begin_drain();
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            e.addr = AW'(i);
            e.data = mem[i];
            e.last = (i == 3);
            exp_q.push_back(e);
        end
        rd_count    = 0;
        done_count  = 0;
        exp_rd_addr = 0;
        cyc         = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 32'({result_rden, out_val, out_last, busy, done,
                        out_data, out_addr, result_rdaddress}), 32'd0);
    endtask

    task automatic run_drain(input logic toggle, input int budget, input string tag);
        int n;
        n = 0;
        while (done_count == 0 && n < budget) begin
            tick(1'b0, toggle ? ((cyc + 1) % 2 == 0) : 1'b1, 1'b1);
            n++;
        end
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b1);
        check({tag, "_done"}, 32'(done_count), 32'd1);
        check({tag, "_reads"}, 32'(rd_count), 32'd4);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        prev_stall = 1'b0;
        reset   = 1'b0;
        start   = 1'b0;
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = DW'(10 + i);
        begin_drain();

        // Power-on reset
        tick(1'b0, 1'b0, 1'b0);
        check_reset_outputs("por_outputs");
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check_reset_outputs("idle_outputs");

        // Full-rate drain: data in cycles 2-5, last in 5, done in 6
        begin_drain();
        for (int k = 0; k < 9; k++) begin
            tick(k == 0, 1'b1, 1'b1);
            check("s1_val", 32'(out_val), 32'(cyc >= 2 && cyc <= 5));
            check("s1_rden", 32'(result_rden), 32'(cyc >= 1 && cyc <= 4));
            check("s1_busy", 32'(busy), 32'(cyc >= 1 && cyc <= 5));
            check("s1_done", 32'(done), 32'(cyc == 6));
            if (cyc == 5) check("s1_last", 32'(out_last), 32'd1);
        end
        check("s1_reads", 32'(rd_count), 32'd4);
        check("s1_done_cnt", 32'(done_count), 32'd1);
        check("s1_drained", 32'(exp_q.size()), 32'd0);

        // Back-pressure for cycles 0-9
        begin_drain();
        for (int k = 0; k < 10; k++) tick(k == 0, 1'b0, 1'b1);
        check("s2_reads_stalled", 32'(rd_count), 32'd2);
        check("s2_head_addr", 32'(out_addr), 32'd0);
        run_drain(1'b0, 30, "s2");

        // Alternating ready
        begin_drain();
        tick(1'b1, 1'b1, 1'b1);
        run_drain(1'b1, 40, "s3");

        // Second start in cycle 3 is ignored
        begin_drain();
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        run_drain(1'b0, 30, "s4");

        // Start coincident with done is ignored
        begin_drain();
        for (int k = 0; k < 6; k++) tick(k == 0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        check("s5_done_cycle", 32'(done), 32'd1);
        tick(1'b0, 1'b1, 1'b1);
        check("s5_no_restart", 32'(busy), 32'd0);
        check("s5_no_rden", 32'(result_rden), 32'd0);
        tick(1'b0, 1'b1, 1'b1);
        check("s5_reads", 32'(rd_count), 32'd4);
        check("s5_done_cnt", 32'(done_count), 32'd1);

        // Reset mid-drain in cycles 3-4, released in 5, then a fresh drain
        begin_drain();
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        check_reset_outputs("s6_rst_c3");
        tick(1'b0, 1'b1, 1'b0);
        check_reset_outputs("s6_rst_c4");
        tick(1'b0, 1'b1, 1'b1);
        check_reset_outputs("s6_release");
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        check("s6_no_done", 32'(done_count), 32'd0);
        check("s6_aborted_idle", 32'(busy), 32'd0);
        begin_drain();
        tick(1'b1, 1'b1, 1'b1);
        run_drain(1'b0, 30, "s6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
